cpu_stage_seq: RTL and testbench
================================

CPU_STAGE_SEQ -- requirements
Module: cpu_stage_seq

Interface
REQ-001 Parameter WAIT_MAX, default 255, sets the memory-wait cycles before a bus timeout; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_run_req  in  1  monitor pulse: start continuous execution.
REQ-005 cpu_step_req  in  1  monitor pulse: execute exactly one instruction.
REQ-006 cpu_halt_req  in  1  monitor pulse: stop at the next instruction boundary.
REQ-007 brk_cntr_en  in  1  enables the free-running-counter breakpoint.
REQ-008 frc_cntr_val_leq  in  1  counter-compare hit; sampled only in WB.
REQ-009 imem_ready  in  1  instruction fetch data valid.
REQ-010 dmem_ready  in  1  load/store data phase complete.
REQ-011 cmd_ldst_ma  in  1  the instruction in MA is a load or store.
REQ-012 cpu_stat_pc / cpu_stat_if / cpu_stat_id / cpu_stat_ex / cpu_stat_ma / cpu_stat_wb  out  1 each  one-hot stage enables.
REQ-013 cpu_stat_before_exec  out  1  high in PC, IF and ID.
REQ-014 cpu_running  out  1  low only in IDLE.
REQ-015 inst_retire  out  1  one-cycle pulse on leaving WB.
REQ-016 instret_cnt  out  32  count of retired instructions.
REQ-017 bus_timeout  out  1  one-cycle pulse when a wait reaches WAIT_MAX.

Function
REQ-018 The state set is IDLE, PC, IF, ID, EX, MA, WB, and exactly one state is active at any time.
REQ-019 Each stage enable is high exactly while its state is active; all enables are low in IDLE.
REQ-020 IDLE goes to PC on cpu_run_req or cpu_step_req, unless the halt request is set (stored bit or cpu_halt_req in the same cycle), in which case it stays in IDLE and clears the stored halt.
REQ-021 PC, ID and EX each last one cycle; the order is PC -> IF -> ID -> EX -> MA -> WB.
REQ-022 IF holds until imem_ready=1, then moves to ID.
REQ-023 MA holds while cmd_ldst_ma=1 and dmem_ready=0; when cmd_ldst_ma=0, MA lasts one cycle.
REQ-024 The wait counter is 8-bit, clears on entering IF or MA, and increments each stalled cycle.
REQ-025 When the wait counter equals WAIT_MAX, the block pulses bus_timeout and forces the state to advance in the following cycle.
REQ-026 WB goes to PC unless the stop condition holds, in which case it goes to IDLE; stop = stored halt | cpu_halt_req | step mode | (brk_cntr_en & frc_cntr_val_leq).
REQ-027 A cpu_halt_req received in any non-IDLE state is latched and takes effect at the next WB; it is never taken mid-instruction.
REQ-028 Step mode is set when leaving IDLE on cpu_step_req without cpu_run_req, and cleared on entering IDLE; if cpu_run_req and cpu_step_req arrive together, run wins.
REQ-029 cpu_run_req and cpu_step_req are ignored outside IDLE.
REQ-030 inst_retire is asserted during the WB cycle; instret_cnt increments by 1 on that edge and wraps from 0xFFFFFFFF to 0.
REQ-031 All outputs are registered or decoded directly from the state register, with no combinational path from the *_req inputs.

Reset
REQ-032 While rst_n=0: state=IDLE, the stored halt and step-mode bits are 0, the wait counter is 0, instret_cnt is 0, and bus_timeout, inst_retire and all stage enables are 0.
REQ-033 Reset asserted mid-instruction abandons that instruction: no retire pulse and no counter update.
REQ-034 After reset is released, the block stays in IDLE until a run or step request arrives.

Structure
REQ-035 The state encoding, the state-count constant and the default WAIT_MAX value belong in the shared package cpu_seq_pkg.
REQ-036 The wait counter with its timeout compare is the sub-module seq_wait_timer, instanced once and cleared by the parent on entry to IF or MA.

Verification
REQ-037 Reset, then cpu_run_req; imem_ready=1, cmd_ldst_ma=0 -> 6-cycle PC..WB loop repeats and instret_cnt=3 after 18 cycles.
REQ-038 From IDLE, cpu_step_req -> exactly one PC..WB pass, one inst_retire pulse, then IDLE with cpu_running=0.
REQ-039 Run, then cpu_halt_req during EX -> current instruction completes WB and the block enters IDLE; no second PC.
REQ-040 cmd_ldst_ma=1 with dmem_ready held 0 and WAIT_MAX=4 -> bus_timeout pulses once after 4 stalled cycles, then WB.
REQ-041 brk_cntr_en=1 with frc_cntr_val_leq=1 at WB -> IDLE; cpu_run_req and cpu_halt_req in the same cycle in IDLE -> stays IDLE.
REQ-042 rst_n low during MA -> all outputs 0 immediately and instret_cnt unchanged from 0 after release.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU stage sequencer.
//   state_t      : sequencer state encoding (IDLE plus the six pipeline stages)
//   STATE_CNT    : number of states in state_t
//   WAIT_MAX_DEF : default memory-wait limit before a bus timeout
//   WAIT_W       : width of the wait counter
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PC   = 3'd1,
      ST_IF   = 3'd2,
      ST_ID   = 3'd3,
      ST_EX   = 3'd4,
      ST_MA   = 3'd5,
      ST_WB   = 3'd6
   } state_t;

   localparam int STATE_CNT    = 7;
   localparam int WAIT_MAX_DEF = 255;
   localparam int WAIT_W       = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait counter with timeout compare.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (entry into a wait-capable stage)
//   stall      : current cycle is a stalled cycle
//   timeout    : registered one-cycle pulse, high in the cycle after the
//                count reaches WAIT_MAX
module seq_wait_timer
   import cpu_seq_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic stall,
   output logic timeout
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_MAX[WAIT_W-1:0];

   logic [WAIT_W-1:0] cnt;
   logic [WAIT_W-1:0] cnt_nxt;

   assign cnt_nxt = cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else if (clr) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else if (stall) begin
         cnt     <= cnt_nxt;
         // Compare against the incremented value so the pulse is registered
         // and lines up with the cycle in which the parent forces the advance.
         timeout <= (cnt_nxt == LIMIT);
      end else begin
         timeout <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_stage_seq.sv
// Multi-cycle CPU stage sequencer: walks PC -> IF -> ID -> EX -> MA -> WB,
// handles run / single-step / halt from a monitor, a counter breakpoint, and
// a memory-wait timeout.
//   cpu_run_req, cpu_step_req, cpu_halt_req : monitor control pulses
//   brk_cntr_en, frc_cntr_val_leq           : counter breakpoint (checked in WB)
//   imem_ready, dmem_ready, cmd_ldst_ma     : memory handshakes
//   cpu_stat_*                              : one-hot stage enables
//   cpu_stat_before_exec, cpu_running       : status decodes
//   inst_retire, instret_cnt                : retire pulse and counter
//   bus_timeout                             : memory-wait timeout pulse
//
// state | meaning
// IDLE  | stopped, waiting for run or step
// PC    | next-PC select
// IF    | instruction fetch, waits for imem_ready
// ID    | decode
// EX    | execute
// MA    | memory access, waits for dmem_ready on loads/stores
// WB    | write-back / retire; stop check happens here
module cpu_stage_seq
   import cpu_seq_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_run_req,
   input  logic        cpu_step_req,
   input  logic        cpu_halt_req,
   input  logic        brk_cntr_en,
   input  logic        frc_cntr_val_leq,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        cmd_ldst_ma,
   output logic        cpu_stat_pc,
   output logic        cpu_stat_if,
   output logic        cpu_stat_id,
   output logic        cpu_stat_ex,
   output logic        cpu_stat_ma,
   output logic        cpu_stat_wb,
   output logic        cpu_stat_before_exec,
   output logic        cpu_running,
   output logic        inst_retire,
   output logic [31:0] instret_cnt,
   output logic        bus_timeout
);

   state_t state;
   state_t state_nxt;
   logic   halt_q;
   logic   step_q;
   logic   halt_any;
   logic   stop;
   logic   wait_clr;
   logic   wait_stall;
   logic   timeout;
   logic [STATE_CNT-2:0] stat_vec;

   assign halt_any = halt_q | cpu_halt_req;
   assign stop     = halt_any | step_q | (brk_cntr_en & frc_cntr_val_leq);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if ((cpu_run_req | cpu_step_req) & ~halt_any) state_nxt = ST_PC;
         ST_PC:   state_nxt = ST_IF;
         ST_IF:   if (imem_ready | timeout) state_nxt = ST_ID;
         ST_ID:   state_nxt = ST_EX;
         ST_EX:   state_nxt = ST_MA;
         ST_MA:   if (~cmd_ldst_ma | dmem_ready | timeout) state_nxt = ST_WB;
         ST_WB:   state_nxt = stop ? ST_IDLE : ST_PC;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      stat_vec = '0;
      case (state)
         ST_PC:   stat_vec[0] = 1'b1;
         ST_IF:   stat_vec[1] = 1'b1;
         ST_ID:   stat_vec[2] = 1'b1;
         ST_EX:   stat_vec[3] = 1'b1;
         ST_MA:   stat_vec[4] = 1'b1;
         ST_WB:   stat_vec[5] = 1'b1;
         default: stat_vec = '0;
      endcase
      cpu_stat_pc          = stat_vec[0];
      cpu_stat_if          = stat_vec[1];
      cpu_stat_id          = stat_vec[2];
      cpu_stat_ex          = stat_vec[3];
      cpu_stat_ma          = stat_vec[4];
      cpu_stat_wb          = stat_vec[5];
      cpu_stat_before_exec = |stat_vec[2:0];
      cpu_running          = (state != ST_IDLE);
      inst_retire          = stat_vec[5];
   end

   // Halt is held until the next WB; both mode bits drop whenever IDLE is
   // entered, so a halt seen together with run/step in IDLE is simply consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_q <= 1'b0;
         step_q <= 1'b0;
      end else begin
         if (state_nxt == ST_IDLE)
            halt_q <= 1'b0;
         else if ((state != ST_IDLE) && cpu_halt_req)
            halt_q <= 1'b1;

         if (state_nxt == ST_IDLE)
            step_q <= 1'b0;
         else if ((state == ST_IDLE) && cpu_step_req && !cpu_run_req)
            step_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               instret_cnt <= '0;
      else if (state == ST_WB)  instret_cnt <= instret_cnt + 32'd1;
   end

   assign wait_clr   = ((state_nxt == ST_IF) && (state != ST_IF)) ||
                       ((state_nxt == ST_MA) && (state != ST_MA));
   assign wait_stall = ((state == ST_IF) && !imem_ready) ||
                       ((state == ST_MA) && cmd_ldst_ma && !dmem_ready);

   seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wait_clr),
      .stall   (wait_stall),
      .timeout (timeout)
   );

   assign bus_timeout = timeout;

endmodule

// File: tb/tb_cpu_stage_seq.sv
module tb_cpu_stage_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_run_req, cpu_step_req, cpu_halt_req;
   logic        brk_cntr_en, frc_cntr_val_leq;
   logic        imem_ready, dmem_ready, cmd_ldst_ma;
   logic        cpu_stat_pc, cpu_stat_if, cpu_stat_id;
   logic        cpu_stat_ex, cpu_stat_ma, cpu_stat_wb;
   logic        cpu_stat_before_exec, cpu_running, inst_retire, bus_timeout;
   logic [31:0] instret_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] ret_q[$];
   logic [5:0]  to_q[$];
   logic [5:0]  stg;

   assign stg = {cpu_stat_wb, cpu_stat_ma, cpu_stat_ex, cpu_stat_id, cpu_stat_if, cpu_stat_pc};

   always #5 clk = ~clk;

   cpu_stage_seq #(.WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_run_req(cpu_run_req), .cpu_step_req(cpu_step_req), .cpu_halt_req(cpu_halt_req),
      .brk_cntr_en(brk_cntr_en), .frc_cntr_val_leq(frc_cntr_val_leq),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .cmd_ldst_ma(cmd_ldst_ma),
      .cpu_stat_pc(cpu_stat_pc), .cpu_stat_if(cpu_stat_if), .cpu_stat_id(cpu_stat_id),
      .cpu_stat_ex(cpu_stat_ex), .cpu_stat_ma(cpu_stat_ma), .cpu_stat_wb(cpu_stat_wb),
      .cpu_stat_before_exec(cpu_stat_before_exec), .cpu_running(cpu_running),
      .inst_retire(inst_retire), .instret_cnt(instret_cnt), .bus_timeout(bus_timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: retire and timeout events pop their expectations.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (inst_retire) begin
            if (ret_q.size() == 0) chk("retire_unexpected", {31'b0, inst_retire}, 32'd0);
            else begin
               chk("retire_cnt", instret_cnt, ret_q.pop_front());
               chk("retire_in_wb", {26'b0, stg}, 32'h20);
            end
         end
         if (bus_timeout) begin
            if (to_q.size() == 0) chk("timeout_unexpected", {31'b0, bus_timeout}, 32'd0);
            else chk("timeout_stage", {26'b0, stg}, {26'b0, to_q.pop_front()});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      cpu_run_req = 0; cpu_step_req = 0; cpu_halt_req = 0;
      brk_cntr_en = 0; frc_cntr_val_leq = 0;
      imem_ready = 1; dmem_ready = 0; cmd_ldst_ma = 0;
      ticks(2);
      chk("rst_stages", {26'b0, stg}, 0);
      chk("rst_running", {31'b0, cpu_running}, 0);
      chk("rst_before_exec", {31'b0, cpu_stat_before_exec}, 0);
      chk("rst_retire", {31'b0, inst_retire}, 0);
      chk("rst_timeout", {31'b0, bus_timeout}, 0);
      chk("rst_instret", instret_cnt, 0);
      rst_n = 1'b1;
      ticks(3);
      chk("idle_after_release", {31'b0, cpu_running}, 0);

      // Continuous run, then halt during EX.
      for (int i = 0; i < 4; i++) ret_q.push_back(i);
      cpu_run_req = 1; ticks(1); cpu_run_req = 0;
      chk("run_pc", {26'b0, stg}, 32'h01);
      chk("run_before_exec_pc", {31'b0, cpu_stat_before_exec}, 1);
      for (int i = 1; i < 6; i++) begin
         ticks(1);
         chk("run_stage_seq", {26'b0, stg}, 32'h1 << i);
         chk("run_before_exec", {31'b0, cpu_stat_before_exec}, (i < 3) ? 32'd1 : 32'd0);
      end
      ticks(13);
      chk("run_instret_18", instret_cnt, 3);
      chk("run_loop_pc", {26'b0, stg}, 32'h01);
      ticks(3);
      chk("halt_in_ex", {26'b0, stg}, 32'h08);
      cpu_halt_req = 1; ticks(1); cpu_halt_req = 0;
      ticks(2);
      chk("halt_idle", {31'b0, cpu_running}, 0);
      chk("halt_instret", instret_cnt, 4);
      ticks(3);
      chk("halt_no_second_pc", {26'b0, stg}, 0);

      // Single step.
      ret_q.push_back(4);
      cpu_step_req = 1; ticks(1); cpu_step_req = 0;
      chk("step_pc", {26'b0, stg}, 32'h01);
      ticks(6);
      chk("step_idle", {31'b0, cpu_running}, 0);
      chk("step_instret", instret_cnt, 5);
      ticks(2);
      chk("step_stays_idle", {31'b0, cpu_running}, 0);

      // Data-side timeout, WAIT_MAX=4.
      cmd_ldst_ma = 1;
      ret_q.push_back(5); to_q.push_back(6'b010000);
      cpu_step_req = 1; ticks(1); cpu_step_req = 0;
      ticks(7);
      chk("ma_stall_stage", {26'b0, stg}, 32'h10);
      chk("ma_no_timeout_yet", {31'b0, bus_timeout}, 0);
      ticks(1);
      chk("ma_timeout_pulse", {31'b0, bus_timeout}, 1);
      ticks(1);
      chk("ma_forced_wb", {26'b0, stg}, 32'h20);
      chk("ma_timeout_single", {31'b0, bus_timeout}, 0);
      ticks(1);
      chk("ma_step_idle", {31'b0, cpu_running}, 0);
      chk("ma_instret", instret_cnt, 6);
      cmd_ldst_ma = 0;

      // Counter breakpoint stops a run after one instruction.
      brk_cntr_en = 1; frc_cntr_val_leq = 1;
      ret_q.push_back(6);
      cpu_run_req = 1; ticks(1); cpu_run_req = 0;
      ticks(6);
      chk("brk_idle", {31'b0, cpu_running}, 0);
      chk("brk_instret", instret_cnt, 7);
      brk_cntr_en = 0; frc_cntr_val_leq = 0;

      // Run and halt together in IDLE.
      cpu_run_req = 1; cpu_halt_req = 1; ticks(1);
      cpu_run_req = 0; cpu_halt_req = 0;
      chk("run_halt_idle", {31'b0, cpu_running}, 0);
      ticks(2);
      chk("run_halt_still_idle", {31'b0, cpu_running}, 0);

      // Halt consumed: next run starts; halt in PC still finishes the instruction.
      ret_q.push_back(7);
      cpu_run_req = 1; ticks(1); cpu_run_req = 0;
      chk("rerun_pc", {26'b0, stg}, 32'h01);
      cpu_halt_req = 1; ticks(1); cpu_halt_req = 0;
      ticks(5);
      chk("rerun_halt_idle", {31'b0, cpu_running}, 0);
      chk("rerun_instret", instret_cnt, 8);

      // Fetch-side timeout.
      imem_ready = 0;
      ret_q.push_back(8); to_q.push_back(6'b000010);
      cpu_step_req = 1; ticks(1); cpu_step_req = 0;
      ticks(4);
      chk("if_stall_stage", {26'b0, stg}, 32'h02);
      chk("if_no_timeout_yet", {31'b0, bus_timeout}, 0);
      ticks(1);
      chk("if_timeout_pulse", {31'b0, bus_timeout}, 1);
      ticks(1);
      chk("if_forced_id", {26'b0, stg}, 32'h04);
      ticks(4);
      chk("if_step_idle", {31'b0, cpu_running}, 0);
      chk("if_instret", instret_cnt, 9);
      imem_ready = 1;

      // Reset during MA.
      cmd_ldst_ma = 1;
      cpu_run_req = 1; ticks(1); cpu_run_req = 0;
      ticks(4);
      chk("pre_rst_ma", {26'b0, stg}, 32'h10);
      rst_n = 1'b0;
      #1;
      chk("rst_ma_stages", {26'b0, stg}, 0);
      chk("rst_ma_running", {31'b0, cpu_running}, 0);
      chk("rst_ma_retire", {31'b0, inst_retire}, 0);
      chk("rst_ma_instret", instret_cnt, 0);
      ticks(2);
      rst_n = 1'b1;
      cmd_ldst_ma = 0;
      ticks(3);
      chk("post_rst_idle", {31'b0, cpu_running}, 0);
      chk("post_rst_instret", instret_cnt, 0);

      chk("retire_queue_empty", ret_q.size(), 0);
      chk("timeout_queue_empty", to_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
